// File: rtl/pulse_gen.sv
// pulse_gen: generates a burst of num_pulses_i pulses. Each pulse is high for
// high_len_i+1 cycles and low for low_len_i+1 cycles.
//
// Optional feature: define PULSE_GEN_LOOP_EN to add loop_i. With loop_i=1 at the end
// of the final low phase, the burst restarts back-to-back and busy_o stays high.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   start_i       burst request; sampled only while idle
//   abort_i       ends the current burst at the next edge (beats start_i when idle)
//   num_pulses_i  pulses per burst; 0 gives an immediate done strobe
//   high_len_i    high phase length minus one
//   low_len_i     low phase length minus one
//   loop_i        (PULSE_GEN_LOOP_EN only) repeat the burst at completion
//   pulse_out_o   registered pulse train
//   busy_o        high while a burst is running
//   done_o        one-cycle strobe at normal burst completion
//   sent_o        rising edges emitted in the current burst
module pulse_gen #(
   parameter int unsigned CNT_W = 3,
   parameter int unsigned TIM_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [CNT_W-1:0] num_pulses_i,
   input  logic [TIM_W-1:0] high_len_i,
   input  logic [TIM_W-1:0] low_len_i,
`ifdef PULSE_GEN_LOOP_EN
   input  logic             loop_i,
`endif
   output logic             pulse_out_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] sent_o
);

   typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

   state_e           state_q;
   logic [TIM_W-1:0] phase_q;
   logic [TIM_W-1:0] high_len_q;
   logic [TIM_W-1:0] low_len_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] sent_q;
   logic             pulse_q;
   logic             busy_q;
   logic             done_q;
   logic             loop_en;

`ifdef PULSE_GEN_LOOP_EN
   assign loop_en = loop_i;
`else
   assign loop_en = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         phase_q    <= '0;
         high_len_q <= '0;
         low_len_q  <= '0;
         count_q    <= '0;
         sent_q     <= '0;
         pulse_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_i && !abort_i) begin
                  if (num_pulses_i != '0) begin
                     count_q    <= num_pulses_i;
                     high_len_q <= high_len_i;
                     low_len_q  <= low_len_i;
                     phase_q    <= '0;
                     sent_q     <= CNT_W'(1);
                     pulse_q    <= 1'b1;
                     busy_q     <= 1'b1;
                     state_q    <= StHigh;
                  end else begin
                     // Empty burst completes at once.
                     sent_q <= '0;
                     done_q <= 1'b1;
                  end
               end
            end
            StHigh: begin
               if (abort_i) begin
                  pulse_q <= 1'b0;
                  busy_q  <= 1'b0;
                  phase_q <= '0;
                  state_q <= StIdle;
               end else if (phase_q == high_len_q) begin
                  phase_q <= '0;
                  pulse_q <= 1'b0;
                  state_q <= StLow;
               end else begin
                  phase_q <= phase_q + TIM_W'(1);
               end
            end
            StLow: begin
               if (abort_i) begin
                  busy_q  <= 1'b0;
                  phase_q <= '0;
                  state_q <= StIdle;
               end else if (phase_q == low_len_q) begin
                  phase_q <= '0;
                  if (sent_q < count_q) begin
                     sent_q  <= sent_q + CNT_W'(1);
                     pulse_q <= 1'b1;
                     state_q <= StHigh;
                  end else if (loop_en) begin
                     // Restart with the latched settings; busy stays high.
                     done_q  <= 1'b1;
                     sent_q  <= CNT_W'(1);
                     pulse_q <= 1'b1;
                     state_q <= StHigh;
                  end else begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= StIdle;
                  end
               end else begin
                  phase_q <= phase_q + TIM_W'(1);
               end
            end
            default: begin
               pulse_q <= 1'b0;
               busy_q  <= 1'b0;
               phase_q <= '0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign pulse_out_o = pulse_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign sent_o      = sent_q;

endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 3, giving the pulse-count width.
REQ-002 The block SHALL have parameter TIM_W, default 4, giving the phase-length width.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: burst request, sampled only in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: terminates the current burst.
REQ-007 The block SHALL have port num_pulses, input, CNT_W bits: pulses per burst, 0..2^CNT_W-1.
REQ-008 The block SHALL have port high_len, input, TIM_W bits: high phase lasts high_len+1 cycles.
REQ-009 The block SHALL have port low_len, input, TIM_W bits: low phase lasts low_len+1 cycles.
REQ-010 The block SHALL have port pulse_out, output, 1 bit: registered pulse train.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in HIGH or LOW state.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle strobe at normal burst completion.
REQ-013 The block SHALL have port sent, output, CNT_W bits: rising edges emitted in the current burst.

Function
REQ-014 The block SHALL implement states IDLE, HIGH and LOW; pulse_out SHALL be 1 exactly in HIGH, and busy SHALL be 1 in HIGH or LOW.
REQ-015 In IDLE, start=1, abort=0 and num_pulses!=0 SHALL latch num_pulses, high_len and low_len, enter HIGH at the next edge, and set sent=1 and the phase counter to 0.
REQ-016 In IDLE, start=1, abort=0 and num_pulses==0 SHALL stay in IDLE, pulse done for one cycle at the next edge, and leave sent=0.
REQ-017 HIGH SHALL last latched high_len+1 cycles and then transition to LOW with the phase counter reset to 0.
REQ-018 LOW SHALL last latched low_len+1 cycles; at its end, if sent < latched count, the block SHALL enter HIGH and increment sent.
REQ-019 At the end of LOW with sent == latched count, the block SHALL enter IDLE, assert done for exactly that one cycle, and hold sent at its final value.
REQ-020 Input changes during a burst SHALL have no effect except abort; start while busy SHALL be ignored.
REQ-021 abort=1 in HIGH or LOW SHALL force IDLE at the next edge with pulse_out=0, done=0 and sent held.
REQ-022 abort and start asserted together in IDLE: abort SHALL win and start SHALL be ignored.
REQ-023 The burst period SHALL be (high_len+1)+(low_len+1) cycles, and the total busy time SHALL be num_pulses times that period.
REQ-024 The phase counter SHALL be TIM_W bits wide and SHALL never wrap; the sent comparison SHALL be done at CNT_W bits, and num_pulses=2^CNT_W-1 SHALL emit exactly that many pulses.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE, pulse_out=0, busy=0, done=0, sent=0, the phase counter to 0, and the latched values to 0.
REQ-026 Reset asserted mid-burst SHALL terminate the burst without a done strobe; the first start after rst_n deasserts SHALL begin a fresh burst.

Configuration
REQ-027 With PULSE_GEN_LOOP_EN defined, the block SHALL have an additional input port loop, 1 bit; if loop=1 at the end of the final LOW, the block SHALL assert done for one cycle, re-enter HIGH with the latched values, set sent=1, and keep busy=1.
REQ-028 Without PULSE_GEN_LOOP_EN, the loop port SHALL NOT exist, and behaviour SHALL be exactly REQ-014..REQ-024.

Verification
REQ-029 Bench SHALL cover: num_pulses=3, high_len=1, low_len=2, start pulse -> pulse_out pattern 11000 repeated 3 times, busy high 15 cycles, sent 1,2,3, done on the 16th cycle.
REQ-030 Bench SHALL cover: num_pulses=0, start -> pulse_out stays 0, busy stays 0, done high for 1 cycle the next cycle.
REQ-031 Bench SHALL cover: num_pulses=7, high_len=0, low_len=0 -> alternating 1010 for 14 cycles, sent=7, single done.
REQ-032 Bench SHALL cover: abort during the 2nd HIGH of a num_pulses=4 burst -> pulse_out=0 next cycle, IDLE, sent=2, no done.
REQ-033 Bench SHALL cover: start re-asserted and num_pulses changed mid-burst -> no effect on the burst; rst_n pulsed mid-LOW -> all outputs 0 immediately.
REQ-034 Bench SHALL cover, with PULSE_GEN_LOOP_EN and loop=1, num_pulses=2: bursts repeat back-to-back, done strobes every 2 pulses, busy never drops.
